// File: rtl/sha_auth_pkg.sv
// sha_auth_pkg: shared encodings for the SHA-256 authenticated key-load sequencer.
// Optional magic-word check is enabled with SHA_AUTH_MAGIC_CHECK_EN.
package sha_auth_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CLR      = 3'd1;
    localparam state_t ST_LOAD_MSG = 3'd2;
    localparam state_t ST_LOAD_DIG = 3'd3;
    localparam state_t ST_GO       = 3'd4;
    localparam state_t ST_WAIT     = 3'd5;
    localparam state_t ST_PASS     = 3'd6;
    localparam state_t ST_FAIL     = 3'd7;

    localparam logic [31:0] SHA_AUTH_MAGIC_W5 = 32'h49535448;
    localparam logic [31:0] SHA_AUTH_MAGIC_W6 = 32'hff484953;
    localparam logic [31:0] SHA_AUTH_MAGIC_W7 = 32'hff484953;

    localparam logic WC_MSG = 1'b0;
    localparam logic WC_DIG = 1'b1;

    localparam logic [2:0] KEY_LO_W = 3'd1;
    localparam logic [2:0] KEY_HI_W = 3'd4;

    function automatic logic is_key_word(input logic [2:0] idx);
        return (idx >= KEY_LO_W) && (idx <= KEY_HI_W);
    endfunction

    function automatic logic [1:0] key_slot(input logic [2:0] idx);
        logic [2:0] off;
        off = idx - KEY_LO_W;
        return off[1:0];
    endfunction

    function automatic logic magic_word_ok(input logic [2:0] idx,
                                           input logic [31:0] w);
        logic ok;
        ok = 1'b1;
        case (idx)
            3'd5:    ok = (w == SHA_AUTH_MAGIC_W5);
            3'd6:    ok = (w == SHA_AUTH_MAGIC_W6);
            3'd7:    ok = (w == SHA_AUTH_MAGIC_W7);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sha_auth_timer.sv
// sha_auth_timer: load/clear/enable up-counter with a terminal-count flag
// raised on the last permitted wait cycle.
module sha_auth_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sha_auth_ctrl.sv
// sha_auth_ctrl: loads message + expected digest into the sha256 core, runs it,
// and releases the AES key on a pass. SHA_AUTH_MAGIC_CHECK_EN adds a magic-word check.
module sha_auth_ctrl
    import sha_auth_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    output logic         sha_reset_n_o,
    output logic         sha_cs_o,
    output logic         sha_we_o,
    output logic         sha_wc_o,
    output logic [2:0]   sha_address_o,
    output logic [31:0]  sha_write_data_o,
    input  logic         sha_digest_valid_i,
    output logic         busy_o,
    output logic         auth_pass_o,
    output logic         auth_fail_o,
    output logic [127:0] key_o,
    output logic         key_valid_o
);

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [127:0]   shadow_q, shadow_d;
    logic [127:0]   key_q, key_d;
    logic           key_valid_q, key_valid_d;
    logic           cs_q, cs_d;
    logic           we_q, we_d;
    logic           wc_q, wc_d;
    logic [2:0]     addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic           tmr_clr, tmr_en, tmr_tc;
    logic           accept, loading, last_word;
`ifdef SHA_AUTH_MAGIC_CHECK_EN
    logic           magic_ok_q, magic_ok_d;
`endif

    sha_auth_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (tmr_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
    );

    assign loading   = (state_q == ST_LOAD_MSG) || (state_q == ST_LOAD_DIG);
    assign accept    = in_valid_i && loading;
    assign last_word = (cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        wc_d        = WC_MSG;
        addr_d      = '0;
        data_d      = '0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
`ifdef SHA_AUTH_MAGIC_CHECK_EN
        magic_ok_d  = magic_ok_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = '0;
                state_d = ST_LOAD_MSG;
`ifdef SHA_AUTH_MAGIC_CHECK_EN
                magic_ok_d = 1'b1;
`endif
            end
            ST_LOAD_MSG, ST_LOAD_DIG: begin
                if (accept) begin
                    cs_d   = 1'b1;
                    we_d   = 1'b1;
                    wc_d   = (state_q == ST_LOAD_DIG) ? WC_DIG : WC_MSG;
                    addr_d = cnt_q;
                    data_d = in_data_i;
                    cnt_d  = cnt_q + 3'd1;
                    if (state_q == ST_LOAD_MSG) begin
                        if (is_key_word(cnt_q)) begin
                            shadow_d[{key_slot(cnt_q), 5'd0} +: 32] = in_data_i;
                        end
`ifdef SHA_AUTH_MAGIC_CHECK_EN
                        if (!magic_word_ok(cnt_q, in_data_i)) begin
                            magic_ok_d = 1'b0;
                        end
`endif
                        if (last_word) begin
                            state_d = ST_LOAD_DIG;
                        end
                    end else if (last_word) begin
`ifdef SHA_AUTH_MAGIC_CHECK_EN
                        state_d = magic_ok_q ? ST_GO : ST_FAIL;
`else
                        state_d = ST_GO;
`endif
                    end
                end
            end
            ST_GO: begin
                cs_d    = 1'b1;
                we_d    = 1'b0;
                tmr_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                // a valid on the terminal cycle still counts as a pass
                if (sha_digest_valid_i) begin
                    key_d       = shadow_q;
                    key_valid_d = 1'b1;
                    state_d     = ST_PASS;
                end else if (tmr_tc) begin
                    state_d = ST_FAIL;
                end
            end
            ST_PASS, ST_FAIL: begin
                shadow_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d     = ST_IDLE;
            shadow_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            cs_d        = 1'b0;
            we_d        = 1'b0;
            wc_d        = WC_MSG;
            addr_d      = '0;
            data_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            wc_q        <= WC_MSG;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            wc_q        <= wc_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

`ifdef SHA_AUTH_MAGIC_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            magic_ok_q <= 1'b0;
        end else begin
            magic_ok_q <= magic_ok_d;
        end
    end
`endif

    assign busy_o           = (state_q != ST_IDLE);
    assign sha_reset_n_o    = (state_q != ST_IDLE);
    assign in_ready_o       = loading;
    assign sha_cs_o         = cs_q;
    assign sha_we_o         = we_q;
    assign sha_wc_o         = wc_q;
    assign sha_address_o    = addr_q;
    assign sha_write_data_o = data_q;
    assign auth_pass_o      = (state_q == ST_PASS) && !abort_i;
    assign auth_fail_o      = (state_q == ST_FAIL) && !abort_i;
    assign key_o            = key_q;
    assign key_valid_o      = key_valid_q;

endmodule

// File: tb/tb_sha_auth_ctrl.sv
// tb_sha_auth_ctrl: directed bench for sha_auth_ctrl with a small sha256-core model.
// Honours SHA_AUTH_MAGIC_CHECK_EN for the magic-word expectations.
module tb_sha_auth_ctrl;

    localparam logic [255:0] MSG1 =
        256'hff484953ff484953495354480123456789abcdef0123456789abcdef00000006;
    localparam logic [255:0] DIG1 =
        256'heb788faedebab8b1f59bfcb007bfed7b809c98a73acab61becccfb3d0435ca46;
    localparam logic [127:0] KEY1 = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [255:0] MSG2 =
        256'hff484953ff484953000000000123456789abcdef0123456789abcdef00000006;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic [31:0]  in_data_i = '0;

    logic         a_ready, a_srst, a_cs, a_we, a_wc, a_busy, a_pass, a_fail, a_kv;
    logic [2:0]   a_addr;
    logic [31:0]  a_data;
    logic [127:0] a_key;
    logic         a_dv;

    logic         b_ready, b_srst, b_cs, b_we, b_wc, b_busy, b_pass, b_fail, b_kv;
    logic [2:0]   b_addr;
    logic [31:0]  b_data;
    logic [127:0] b_key;
    logic         b_dv = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    sha_auth_ctrl dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_ready), .in_data_i(in_data_i),
        .sha_reset_n_o(a_srst), .sha_cs_o(a_cs), .sha_we_o(a_we), .sha_wc_o(a_wc),
        .sha_address_o(a_addr), .sha_write_data_o(a_data),
        .sha_digest_valid_i(a_dv), .busy_o(a_busy), .auth_pass_o(a_pass),
        .auth_fail_o(a_fail), .key_o(a_key), .key_valid_o(a_kv)
    );

    sha_auth_ctrl #(.TIMEOUT_CYCLES(16), .TMR_W(5)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_ready), .in_data_i(in_data_i),
        .sha_reset_n_o(b_srst), .sha_cs_o(b_cs), .sha_we_o(b_we), .sha_wc_o(b_wc),
        .sha_address_o(b_addr), .sha_write_data_o(b_data),
        .sha_digest_valid_i(b_dv), .busy_o(b_busy), .auth_pass_o(b_pass),
        .auth_fail_o(b_fail), .key_o(b_key), .key_valid_o(b_kv)
    );

    // Core model: knows one message/digest pair, asserts valid 40 cycles after start.
    logic [31:0] m_msg [8];
    logic [31:0] m_dig [8];
    logic        m_armed;
    int          m_cnt;
    logic        m_match;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || !a_srst) begin
            m_armed <= 1'b0;
            m_cnt   <= 0;
            for (int i = 0; i < 8; i++) begin
                m_msg[i] <= '0;
                m_dig[i] <= '0;
            end
        end else begin
            if (a_cs && a_we) begin
                if (a_wc) m_dig[a_addr] <= a_data;
                else      m_msg[a_addr] <= a_data;
            end
            if (a_cs && !a_we) begin
                m_armed <= 1'b1;
                m_cnt   <= 1;
            end else if (m_armed && m_cnt < 100000) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign m_match =
        ({m_msg[7], m_msg[6], m_msg[5], m_msg[4],
          m_msg[3], m_msg[2], m_msg[1], m_msg[0]} == MSG1) &&
        ({m_dig[7], m_dig[6], m_dig[5], m_dig[4],
          m_dig[3], m_dig[2], m_dig[1], m_dig[0]} == DIG1);
    assign a_dv = m_armed && (m_cnt >= 40) && m_match;

    // Event monitors
    logic [35:0] wr_q [$];
    int a_go_n = 0, a_go_cyc = 0, a_pass_n = 0, a_pass_cyc = 0;
    int a_fail_n = 0, a_fail_cyc = 0;
    int b_go_cyc = 0, b_fail_n = 0, b_fail_cyc = 0;

    always @(negedge clk_i) begin
        if (a_cs && !a_we) begin a_go_n++; a_go_cyc = cyc; end
        if (a_cs && a_we) wr_q.push_back({a_wc, a_addr, a_data});
        if (a_pass) begin a_pass_n++; a_pass_cyc = cyc; end
        if (a_fail) begin a_fail_n++; a_fail_cyc = cyc; end
        if (b_cs && !b_we) b_go_cyc = cyc;
        if (b_fail) begin b_fail_n++; b_fail_cyc = cyc; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        if (gap > 0) tick(gap);
        in_valid_i = 1'b1;
        in_data_i  = w;
        n = 0;
        @(negedge clk_i);
        while (!a_ready && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 64) chk("ready_wait", a_ready, 1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic session(input logic [255:0] msg, input logic [255:0] dig,
                           input int gap, input int nwords);
        pulse_start();
        for (int k = 0; k < nwords && k < 16; k++) begin
            if (k < 8) send(msg[32*k +: 32], gap);
            else       send(dig[32*(k-8) +: 32], gap);
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (a_busy && n < limit) begin
            tick(1);
            n++;
        end
        chk("done_wait", a_busy, 0);
        tick(1);
    endtask

    initial begin
        int p0, f0, g0, bf0;
        logic [35:0] ent;

        // reset
        tick(3);
        chk("rst_srst", a_srst, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_key", {a_key, a_kv}, 0);
        chk("rst_bus", {a_cs, a_we, a_wc, a_addr, a_data}, 0);
        rst_i = 1'b1;
        tick(2);

        // passing load, write trace, and timeout on the short-timer instance
        wr_q.delete();
        p0 = a_pass_n; f0 = a_fail_n; g0 = a_go_n; bf0 = b_fail_n;
        session(MSG1, DIG1, 0, 16);
        wait_done(200);
        chk("t1_pass_n", a_pass_n - p0, 1);
        chk("t1_fail_n", a_fail_n - f0, 0);
        chk("t1_pass_lat", a_pass_cyc - a_go_cyc, 41);
        chk("t1_key", a_key, KEY1);
        chk("t1_kv", a_kv, 1);
        chk("tr_nwr", wr_q.size(), 16);
        chk("tr_ngo", a_go_n - g0, 1);
        for (int k = 0; k < 16 && k < wr_q.size(); k++) begin
            ent = (k < 8) ? {1'b0, 3'(k), MSG1[32*k +: 32]}
                          : {1'b1, 3'(k - 8), DIG1[32*(k-8) +: 32]};
            chk($sformatf("tr_wr%0d", k), wr_q[k], ent);
        end
        chk("to_fail_n", b_fail_n - bf0, 1);
        chk("to_lat", b_fail_cyc - b_go_cyc, 16);
        chk("to_key", {b_key, b_kv}, 0);

        // abort after the fifth digest word, then a full passing session
        p0 = a_pass_n; f0 = a_fail_n; bf0 = b_fail_n;
        session(MSG1, DIG1, 0, 13);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        chk("ab_busy", a_busy, 0);
        chk("ab_srst", a_srst, 0);
        chk("ab_cs", a_cs, 0);
        chk("ab_key", {a_key, a_kv}, 0);
        tick(60);
        chk("ab_pulses", {a_pass_n - p0, a_fail_n - f0, b_fail_n - bf0}, 0);
        session(MSG1, DIG1, 0, 16);
        wait_done(200);
        chk("ab_pass_n", a_pass_n - p0, 1);
        chk("ab_key2", a_key, KEY1);

        // magic word 5 corrupted
        p0 = a_pass_n; f0 = a_fail_n; g0 = a_go_n;
        session(MSG2, DIG1, 0, 16);
        wait_done(1300);
        chk("mg_pass_n", a_pass_n - p0, 0);
        chk("mg_fail_n", a_fail_n - f0, 1);
        chk("mg_key", {a_key, a_kv}, 0);
`ifdef SHA_AUTH_MAGIC_CHECK_EN
        chk("mg_ngo", a_go_n - g0, 0);
`else
        chk("mg_ngo", a_go_n - g0, 1);
        chk("mg_lat", a_fail_cyc - a_go_cyc, 1024);
`endif

        // gapped words, start while busy, words outside the load window
        wr_q.delete();
        p0 = a_pass_n; f0 = a_fail_n; g0 = a_go_n;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            if (k < 8) send(MSG1[32*k +: 32], (k % 3) + 1);
            else       send(DIG1[32*(k-8) +: 32], (k % 2) + 2);
            if (k == 3) pulse_start();
        end
        in_valid_i = 1'b1;
        in_data_i  = 32'hdeadbeef;
        start_i    = 1'b1;
        tick(5);
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        wait_done(200);
        chk("bp_pass_n", a_pass_n - p0, 1);
        chk("bp_fail_n", a_fail_n - f0, 0);
        chk("bp_ngo", a_go_n - g0, 1);
        chk("bp_lat", a_pass_cyc - a_go_cyc, 41);
        chk("bp_nwr", wr_q.size(), 16);
        chk("bp_key", a_key, KEY1);

        // reset asserted mid-cycle while waiting on the core
        p0 = a_pass_n;
        session(MSG1, DIG1, 0, 16);
        tick(10);
        chk("rw_busy", a_busy, 1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rw_a_outs", {a_ready, a_srst, a_cs, a_we, a_wc, a_addr, a_data,
                          a_busy, a_pass, a_fail, a_key, a_kv}, 0);
        chk("rw_b_outs", {b_ready, b_srst, b_cs, b_we, b_wc, b_addr, b_data,
                          b_busy, b_pass, b_fail, b_key, b_kv}, 0);
        tick(3);
        rst_i = 1'b1;
        tick(60);
        chk("rw_no_pass", a_pass_n - p0, 0);
        chk("rw_key", {a_key, a_kv}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
